// File: rtl/alsu_pkg.sv
// Shared opcode constants, FSM state type and opcode classification for alsu_stream.
package alsu_pkg;

    localparam logic [2:0] OP_AND   = 3'b000;
    localparam logic [2:0] OP_XOR   = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_MUL   = 3'b011;
    localparam logic [2:0] OP_SHIFT = 3'b100;
    localparam logic [2:0] OP_ROT   = 3'b101;

    typedef enum logic [1:0] {IDLE, EXEC, MULT, BLINK} alsu_state_t;

    // Without the multiplier, OP_MUL is treated like the 11x codes.
    function automatic logic is_invalid(input logic [2:0] op, input logic mult_en);
        return (op[2:1] == 2'b11) || ((op == OP_MUL) && !mult_en);
    endfunction

endpackage

// File: rtl/alsu_seq_mult.sv
// Iterative shift-add multiplier: one partial product per clock, done pulses while the last one is summed.
module alsu_seq_mult #(
    parameter int WIDTH = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] p
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;

    assign acc_next = acc + (mplier[0] ? mcand : '0);
    // p is the finished product in the cycle done is high, so the caller can register it on that edge.
    assign p        = acc_next;
    assign done     = (cnt == CW'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else if (start) begin
            acc    <= '0;
            mcand  <= (2*WIDTH)'(a);
            mplier <= b;
            cnt    <= CW'(WIDTH);
        end else if (cnt != '0) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/alsu_stream.sv
// Handshaked ALSU: logic, add, shift/rotate, optional iterative multiply, invalid-opcode LED blink.
// Define ALSU_MULT_EN to compile in the multiplier; otherwise opcode 011 is invalid.
//
// state | meaning
// IDLE  | in_ready high, waiting for a transfer
// EXEC  | single-cycle op, result written on leaving
// MULT  | shift-add multiply in progress
// BLINK | invalid opcode, LED blink sequence running
module alsu_stream
    import alsu_pkg::*;
#(
    parameter int    WIDTH          = 3,
    parameter string INPUT_PRIORITY = "A",
    parameter string FULL_ADDER     = "ON",
    parameter int    LED_W          = 16,
    parameter int    BLINK_PERIOD   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic [2:0]         opcode,
    input  logic               cin,
    input  logic               serial_in,
    input  logic               direction,
    input  logic               red_op_A,
    input  logic               red_op_B,
    input  logic               bypass_A,
    input  logic               bypass_B,
    output logic [2*WIDTH-1:0] out,
    output logic               out_valid,
    output logic               err,
    output logic [LED_W-1:0]   led
);
    localparam int OW        = 2 * WIDTH;
    localparam bit PRIO_A    = (INPUT_PRIORITY == "A");
    localparam bit FA_ON     = (FULL_ADDER == "ON");
    localparam int BLINK_CYC = 4 * BLINK_PERIOD;
    localparam int CNT_W     = $clog2(BLINK_CYC + 1);
    localparam logic [CNT_W-1:0] TC_1 = CNT_W'(BLINK_PERIOD);
    localparam logic [CNT_W-1:0] TC_2 = CNT_W'(2 * BLINK_PERIOD);
    localparam logic [CNT_W-1:0] TC_3 = CNT_W'(3 * BLINK_PERIOD);
    localparam logic [CNT_W-1:0] TC_4 = CNT_W'(BLINK_CYC);
`ifdef ALSU_MULT_EN
    localparam bit MULT_EN = 1'b1;
`else
    localparam bit MULT_EN = 1'b0;
`endif

    alsu_state_t state, state_n;

    logic [WIDTH-1:0] a_r, b_r;
    logic [2:0]       op_r;
    logic             cin_r, sin_r, dir_r, ra_r, rb_r, ba_r, bb_r;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             xfer, in_bad, blink_on;
    logic [WIDTH-1:0] byp_sel, red_sel;
    logic [WIDTH:0]   sum;
    logic [OW-1:0]    exec_val;
    logic             mult_done;
    logic [OW-1:0]    mult_p;

    assign in_ready = (state == IDLE);
    assign xfer     = in_valid && in_ready;
    assign in_bad   = is_invalid(opcode, MULT_EN);

`ifdef ALSU_MULT_EN
    alsu_seq_mult #(.WIDTH(WIDTH)) u_mult (
        .clk   (clk),
        .rst   (rst),
        .start (xfer && (opcode == OP_MUL)),
        .a     (A),
        .b     (B),
        .done  (mult_done),
        .p     (mult_p)
    );
`else
    assign mult_done = 1'b0;
    assign mult_p    = '0;
`endif

    always_comb begin
        exec_val = '0;
        byp_sel  = (ba_r && bb_r) ? (PRIO_A ? a_r : b_r) : (ba_r ? a_r : b_r);
        red_sel  = (ra_r && rb_r) ? (PRIO_A ? a_r : b_r) : (ra_r ? a_r : b_r);
        sum      = {1'b0, a_r} + {1'b0, b_r} + (WIDTH+1)'(FA_ON & cin_r);
        if (ba_r || bb_r) begin
            exec_val = OW'(byp_sel);
        end else begin
            case (op_r)
                OP_AND:   exec_val = (ra_r || rb_r) ? OW'(&red_sel) : OW'(a_r & b_r);
                OP_XOR:   exec_val = (ra_r || rb_r) ? OW'(^red_sel) : OW'(a_r ^ b_r);
                OP_ADD:   exec_val = OW'(sum);
                OP_SHIFT: exec_val = dir_r ? {out[OW-2:0], sin_r} : {sin_r, out[OW-1:1]};
                OP_ROT:   exec_val = dir_r ? {out[OW-2:0], out[OW-1]} : {out[0], out[OW-1:1]};
                default:  exec_val = '0;
            endcase
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (xfer) begin
                    if (in_bad)                  state_n = BLINK;
                    else if (opcode == OP_MUL)   state_n = MULT;
                    else                         state_n = EXEC;
                end
            end
            EXEC:    state_n = IDLE;
            MULT:    if (mult_done) state_n = IDLE;
            BLINK:   if (cnt == '0) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // cnt counts down from TC_4; the phase is derived from the post-decrement value.
    assign cnt_n    = cnt - 1'b1;
    assign blink_on = (cnt_n >= TC_3) || ((cnt_n >= TC_1) && (cnt_n < TC_2));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_r       <= '0;
            b_r       <= '0;
            op_r      <= '0;
            cin_r     <= 1'b0;
            sin_r     <= 1'b0;
            dir_r     <= 1'b0;
            ra_r      <= 1'b0;
            rb_r      <= 1'b0;
            ba_r      <= 1'b0;
            bb_r      <= 1'b0;
            cnt       <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            err       <= 1'b0;
            led       <= '0;
        end else begin
            out_valid <= 1'b0;
            if (xfer) begin
                a_r   <= A;
                b_r   <= B;
                op_r  <= opcode;
                cin_r <= cin;
                sin_r <= serial_in;
                dir_r <= direction;
                ra_r  <= red_op_A;
                rb_r  <= red_op_B;
                ba_r  <= bypass_A;
                bb_r  <= bypass_B;
                if (in_bad) cnt <= TC_4;
                else        err <= 1'b0;
            end
            case (state)
                EXEC: begin
                    out       <= exec_val;
                    out_valid <= 1'b1;
                end
                MULT: begin
                    if (mult_done) begin
                        out       <= (ba_r || bb_r) ? exec_val : mult_p;
                        out_valid <= 1'b1;
                    end
                end
                BLINK: begin
                    if (cnt == TC_4) begin
                        out       <= '0;
                        err       <= 1'b1;
                        out_valid <= 1'b1;
                    end
                    if (cnt != '0) begin
                        cnt <= cnt_n;
                        led <= {LED_W{blink_on}};
                    end else begin
                        led <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alsu_stream.sv
// Scoreboard bench for alsu_stream: two instances (priority A / full adder, priority B / no cin) share one stimulus bus.
module tb_alsu_stream;
    localparam int W  = 3;
    localparam int OW = 2 * W;
    localparam int BP = 2;
`ifdef ALSU_MULT_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif
    localparam logic [6:0] F_NONE = 7'b0000000;
    localparam logic [6:0] F_CIN  = 7'b1000000;
    localparam logic [6:0] F_SIN  = 7'b0100000;
    localparam logic [6:0] F_DIR  = 7'b0010000;
    localparam logic [6:0] F_RA   = 7'b0001000;
    localparam logic [6:0] F_RB   = 7'b0000100;
    localparam logic [6:0] F_BA   = 7'b0000010;
    localparam logic [6:0] F_BB   = 7'b0000001;

    logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic [2:0] opcode = '0;
    logic cin = 0, serial_in = 0, direction = 0, red_op_A = 0, red_op_B = 0, bypass_A = 0, bypass_B = 0;

    logic in_ready0, out_valid0, err0, in_ready1, out_valid1, err1;
    logic [OW-1:0] out0, out1;
    logic [15:0] led0, led1;

    int n_tests = 0, n_fail = 0, cyc = 0;

    typedef struct {
        logic [OW-1:0] out;
        logic          err;
        int            due;
    } exp_t;
    exp_t q0[$], q1[$];
    exp_t e0, e1;
    logic [OW-1:0] m_out0 = '0, m_out1 = '0;
    logic prev_ov0 = 1'b0, prev_ov1 = 1'b0;

    alsu_stream #(.WIDTH(W), .INPUT_PRIORITY("A"), .FULL_ADDER("ON"), .LED_W(16), .BLINK_PERIOD(BP)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .A(a), .B(b), .opcode(opcode),
        .cin(cin), .serial_in(serial_in), .direction(direction), .red_op_A(red_op_A), .red_op_B(red_op_B),
        .bypass_A(bypass_A), .bypass_B(bypass_B), .out(out0), .out_valid(out_valid0), .err(err0), .led(led0));

    alsu_stream #(.WIDTH(W), .INPUT_PRIORITY("B"), .FULL_ADDER("OFF"), .LED_W(16), .BLINK_PERIOD(BP)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .A(a), .B(b), .opcode(opcode),
        .cin(cin), .serial_in(serial_in), .direction(direction), .red_op_A(red_op_A), .red_op_B(red_op_B),
        .bypass_A(bypass_A), .bypass_B(bypass_B), .out(out1), .out_valid(out_valid1), .err(err1), .led(led1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Returns {err, out} for one transfer.
    function automatic logic [OW:0] model(input bit pa, input bit fa, input logic [OW-1:0] cur,
                                          input logic [2:0] op, input logic [W-1:0] ta, input logic [W-1:0] tb,
                                          input logic [6:0] f);
        logic [W-1:0] s;
        logic [OW-1:0] r;
        logic tc, ts, td, tra, trb, tba, tbb;
        {tc, ts, td, tra, trb, tba, tbb} = f;
        r = '0;
        if (op == 3'b110 || op == 3'b111 || (op == 3'b011 && !MUL_EN)) return {1'b1, {OW{1'b0}}};
        if (tba || tbb) begin
            s = (tba && tbb) ? (pa ? ta : tb) : (tba ? ta : tb);
            return {1'b0, OW'(s)};
        end
        case (op)
            3'b000, 3'b001: begin
                if (tra || trb) begin
                    s = (tra && trb) ? (pa ? ta : tb) : (tra ? ta : tb);
                    r = OW'(op[0] ? ^s : &s);
                end else begin
                    r = OW'(op[0] ? (ta ^ tb) : (ta & tb));
                end
            end
            3'b010:  r = OW'(ta) + OW'(tb) + OW'(fa & tc);
            3'b011:  r = OW'(ta) * OW'(tb);
            3'b100:  r = td ? {cur[OW-2:0], ts} : {ts, cur[OW-1:1]};
            3'b101:  r = td ? {cur[OW-2:0], cur[OW-1]} : {cur[0], cur[OW-1:1]};
            default: r = '0;
        endcase
        return {1'b0, r};
    endfunction

    // Returns 1 after the transfer edge (+1 time unit).
    task automatic do_op(input logic [2:0] op, input logic [W-1:0] ta, input logic [W-1:0] tb,
                         input logic [6:0] f, input bit push);
        int waited;
        int lat;
        logic [OW:0] r0, r1;
        waited = 0;
        @(negedge clk);
        opcode = op; a = ta; b = tb;
        {cin, serial_in, direction, red_op_A, red_op_B, bypass_A, bypass_B} = f;
        in_valid = 1'b1;
        while (!in_ready0 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        chk("ready_wait", 32'(waited < 100), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (push) begin
            r0  = model(1'b1, 1'b1, m_out0, op, ta, tb, f);
            r1  = model(1'b0, 1'b0, m_out1, op, ta, tb, f);
            lat = (op == 3'b011 && MUL_EN) ? W : 1;
            q0.push_back('{out: r0[OW-1:0], err: r0[OW], due: cyc + lat});
            q1.push_back('{out: r1[OW-1:0], err: r1[OW], due: cyc + lat});
            m_out0 = r0[OW-1:0];
            m_out1 = r1[OW-1:0];
        end
    endtask

    task automatic check_blink();
        logic [15:0] exp_led;
        for (int k = 1; k <= 4*BP + 1; k++) begin
            @(posedge clk);
            #1;
            exp_led = (k <= 4*BP && (((k - 1) / BP) % 2) == 0) ? 16'hFFFF : 16'h0000;
            chk("led0", 32'(led0), 32'(exp_led));
            chk("led1", 32'(led1), 32'(exp_led));
            chk("blink_ready", 32'(in_ready0), 32'(k == 4*BP + 1));
            chk("blink_err", 32'(err0), 32'd1);
        end
    endtask

    task automatic check_mult_busy();
        for (int k = 1; k <= W; k++) begin
            @(posedge clk);
            #1;
            chk("mul_ready", 32'(in_ready0), 32'(k == W));
        end
    endtask

    always @(negedge clk) begin
        if (out_valid0) begin
            chk("ov_pulse0", 32'(prev_ov0), 32'd0);
            chk("q0_nonempty", 32'(q0.size() > 0), 32'd1);
            if (q0.size() > 0) begin
                e0 = q0.pop_front();
                chk("out0", 32'(out0), 32'(e0.out));
                chk("err0", 32'(err0), 32'(e0.err));
                chk("lat0", cyc, e0.due);
            end
        end
        if (out_valid1) begin
            chk("ov_pulse1", 32'(prev_ov1), 32'd0);
            chk("q1_nonempty", 32'(q1.size() > 0), 32'd1);
            if (q1.size() > 0) begin
                e1 = q1.pop_front();
                chk("out1", 32'(out1), 32'(e1.out));
                chk("err1", 32'(err1), 32'(e1.err));
                chk("lat1", cyc, e1.due);
            end
        end
        prev_ov0 = out_valid0;
        prev_ov1 = out_valid1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests %0d", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out", 32'(out0), 32'd0);
        chk("rst_ov", 32'(out_valid0), 32'd0);
        chk("rst_err", 32'(err0), 32'd0);
        chk("rst_led", 32'(led0), 32'd0);
        chk("rst_ready", 32'(in_ready0), 32'd1);
        rst = 1'b0;

        do_op(3'b000, 3'b101, 3'b011, F_NONE, 1'b1);
        do_op(3'b000, 3'b101, 3'b011, F_RA | F_RB, 1'b1);
        do_op(3'b000, 3'b111, 3'b011, F_RA | F_RB, 1'b1);
        do_op(3'b001, 3'b110, 3'b011, F_NONE, 1'b1);
        do_op(3'b001, 3'b111, 3'b010, F_RA, 1'b1);
        do_op(3'b001, 3'b011, 3'b111, F_RA | F_RB, 1'b1);
        do_op(3'b010, 3'd7, 3'd7, F_CIN, 1'b1);
        do_op(3'b010, 3'd0, 3'd5, F_NONE, 1'b1);
        do_op(3'b010, 3'd3, 3'd1, F_RA | F_RB, 1'b1);

        do_op(3'b011, 3'd7, 3'd6, F_NONE, 1'b1);
        if (MUL_EN) check_mult_busy();
        else        check_blink();

        do_op(3'b000, 3'b101, 3'b011, F_NONE, 1'b1);
        do_op(3'b100, 3'd0, 3'd0, F_SIN | F_DIR, 1'b1);
        do_op(3'b101, 3'd0, 3'd0, F_NONE, 1'b1);
        do_op(3'b100, 3'd0, 3'd0, F_NONE, 1'b1);
        do_op(3'b101, 3'd0, 3'd0, F_DIR, 1'b1);

        do_op(3'b110, 3'd1, 3'd2, F_NONE, 1'b1);
        check_blink();
        do_op(3'b000, 3'd1, 3'd1, F_NONE, 1'b1);
        @(posedge clk);
        #1;
        chk("err_cleared", 32'(err0), 32'd0);
        do_op(3'b111, 3'd3, 3'd3, F_BA, 1'b1);
        check_blink();

        do_op(3'b100, 3'd5, 3'd2, F_BA | F_BB, 1'b1);
        do_op(3'b000, 3'd5, 3'd2, F_BA, 1'b1);
        do_op(3'b000, 3'd5, 3'd2, F_BB, 1'b1);

        // Abort a multiply (or, without the multiplier, the blink it turns into) with rst.
        do_op(3'b011, 3'd7, 3'd6, F_NONE, !MUL_EN);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_out0 = '0;
        m_out1 = '0;
        chk("abort_out", 32'(out0), 32'd0);
        chk("abort_ready", 32'(in_ready0), 32'd1);
        chk("abort_led", 32'(led0), 32'd0);
        chk("abort_err", 32'(err0), 32'd0);
        repeat (4) @(posedge clk);

        do_op(3'b000, 3'd5, 3'd3, F_BA | F_BB, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alsu_stream.md
# alsu_stream

Parametrised, handshaked successor to the team's 3-bit ALSU. It accepts one operation per valid/ready transfer and executes AND/XOR (bitwise or reduction), add, multiply, and serial shift/rotate at a configurable operand width. It signals invalid opcodes with a sticky error flag and a timed LED blink sequence. It sits between the switch/button front end and the display logic, and replaces the free-running ALSU wherever operands arrive from a controller rather than directly from switches.

## Interface
Parameters:
- WIDTH, 3, operand width; result width is 2*WIDTH
- INPUT_PRIORITY, "A", operand chosen when both bypass flags or both reduction flags are set ("A" or "B")
- FULL_ADDER, "ON", "ON" adds cin; "OFF" ignores cin
- LED_W, 16, LED bus width
- BLINK_PERIOD, 4, cycles per LED on/off phase (must be ≥1)

Ports (clock and reset are one clock; reset is synchronous and active-high):
- clk  in  1  clock, all logic on its rising edge
- rst  in  1  synchronous active-high reset
- in_valid  in  1  operation request
- in_ready  out  1  block can accept an operation
- A, B  in  WIDTH  operands
- opcode  in  3  operation select
- cin, serial_in, direction, red_op_A, red_op_B, bypass_A, bypass_B  in  1 each  operation modifiers
- out  out  2*WIDTH  result register
- out_valid  out  1  one-cycle pulse when out is updated
- err  out  1  sticky invalid-opcode flag
- led  out  LED_W  error blink output

## Operation
- FSM states are IDLE, EXEC, MULT and BLINK. in_ready = (state == IDLE). A transfer occurs when in_valid && in_ready, and it captures every input into the registers.
- The transfer moves the FSM to MULT when the opcode is 011 (macro enabled), to BLINK when the opcode is 11x or 011 with the macro disabled, and to EXEC otherwise.
- A transfer that is not invalid clears err.
- Bypass takes precedence over the opcode:
  - Both bypass flags set: out = the priority operand, zero-extended.
  - Only bypass_A set: out = A. Only bypass_B set: out = B.
- 000 AND:
  - Both red flags set: out = &(priority operand).
  - Only red_op_A set: out = &A. Only red_op_B set: out = &B.
  - Neither set: out = A & B.
  - All results are zero-extended.
- 001 XOR: same selection rules as 000, using ^.
- 010 add: out = A + B + (FULL_ADDER=="ON" ? cin : 0). The result is WIDTH+1 bits, zero-extended.
- 011 multiply: out = A*B, full 2*WIDTH bits, computed by an iterative shift-add.
- 100 shift on the current out:
  - direction=1: out = {out[2W-2:0], serial_in}.
  - direction=0: out = {serial_in, out[2W-1:1]}.
- 101 rotate on the current out:
  - direction=1: rotate left by 1.
  - direction=0: rotate right by 1.
- 11x invalid: out = 0, err = 1, then the FSM enters BLINK.
  - led = all ones for BLINK_PERIOD cycles, then all zeros for BLINK_PERIOD, then ones, then zeros.
  - After 4*BLINK_PERIOD cycles the FSM returns to IDLE with led = 0.
- Red flags are ignored for opcodes other than 000 and 001.
- Inputs presented while in_ready=0 are ignored. The source holds them until the transfer.

## Timing
- Reset values: out=0, out_valid=0, err=0, led=0, in_ready=1, FSM in IDLE, all input registers 0.
- A rst during any state returns the block to IDLE on the same edge, aborts any multiply or blink, and produces no out_valid.
- EXEC ops: transfer at edge N; out and out_valid are updated at edge N+1; in_ready is high after N+1. The next transfer occurs at edge N+2 at the earliest.
- MULT: transfer at edge N; one partial product per edge; out is written at edge N+WIDTH with out_valid high for one cycle after that edge. in_ready is low during cycles N+1..N+WIDTH.
- BLINK: transfer at edge N; out=0, err=1 and out_valid are written at edge N+1, and led goes to ones at the same edge. in_ready stays low until edge N+1+4*BLINK_PERIOD.
- out_valid is never high for two consecutive cycles.

## Configuration
- ALSU_MULT_EN defined: the iterative multiplier is compiled in, and opcode 011 executes as described.
- ALSU_MULT_EN undefined: no multiplier logic exists, and opcode 011 is handled exactly like 11x (invalid, err, blink).

## Structure
- Package alsu_pkg holds:
  - the opcode constants OP_AND=3'b000, OP_XOR=3'b001, OP_ADD=3'b010, OP_MUL=3'b011, OP_SHIFT=3'b100, OP_ROT=3'b101;
  - the state enum {IDLE, EXEC, MULT, BLINK}.
- Sub-module alsu_seq_mult is a parametrised WIDTH shift-add multiplier with ports clk, rst, start, a, b, done (one-cycle pulse) and p[2*WIDTH-1:0]. It is instantiated only under ALSU_MULT_EN.

## Test plan
- Logic ops: A=3'b101, B=3'b011, opcode 000, no flags → out=6'b000001 with out_valid one cycle after the transfer. Repeat with red_op_A=red_op_B=1 and INPUT_PRIORITY "B" → out=&3'b011=0.
- Add: FULL_ADDER "ON", A=7, B=7, cin=1, opcode 010 → out=6'd15. Repeat with FULL_ADDER "OFF" → out=6'd14.
- Multiply: macro on, A=7, B=6, opcode 011 → out=6'd42 at edge N+3; in_ready low for 3 cycles. Repeat with the macro off → err=1, out=0.
- Shift and rotate: start from out=6'b000001. Opcode 100, direction=1, serial_in=1 → 6'b000011. Then opcode 101, direction=0 → 6'b100001.
- Invalid opcode: opcode 110 with BLINK_PERIOD=2 → out=0, err=1; led=16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000 for 2 cycles each; in_ready returns after 8 cycles. The next valid op clears err.
- Reset and bypass: assert rst at cycle 2 of a multiply → out=0, in_ready=1, and no out_valid. Then bypass_A=bypass_B=1 with INPUT_PRIORITY "A", A=5 → out=6'd5.
